// File: rtl/tinyqv_timer_pkg.sv
// Shared constants for the TinyQV multi-slot timer scheduler: register map and
// comparator window width.
package tinyqv_timer_pkg;

    localparam logic [2:0] ADDR_CMP0    = 3'd0;
    localparam logic [2:0] ADDR_CMP1    = 3'd1;
    localparam logic [2:0] ADDR_CMP2    = 3'd2;
    localparam logic [2:0] ADDR_CMP3    = 3'd3;
    localparam logic [2:0] ADDR_ENABLE  = 3'd4;
    localparam logic [2:0] ADDR_ONESHOT = 3'd5;
    localparam logic [2:0] ADDR_PENDING = 3'd6;
    localparam logic [2:0] ADDR_IRQ_EN  = 3'd7;

    localparam int unsigned MAX_SLOTS   = 4;
    // Top bits of (mtime - cmp) that must be zero for a hit.
    localparam int unsigned WINDOW_BITS = 2;

endpackage

// File: rtl/tinyqv_timer_cmp.sv
// Wrap-aware compare: hits when mtime is at or past cmp by less than 2^30 ticks.
module tinyqv_timer_cmp
    import tinyqv_timer_pkg::*;
(
    input  logic [31:0] mtime,
    input  logic [31:0] cmp,
    input  logic        en,
    output logic        hit
);

    logic [31:0] diff;

    always_comb begin
        diff = mtime - cmp;
        hit  = en && (diff[31 -: WINDOW_BITS] == '0);
    end

endmodule

// File: rtl/tinyqv_timer_sched.sv
// Multi-slot timer scheduler: one shared comparator scans a compare slot per clock,
// latching pending flags that drive a single level interrupt.
module tinyqv_timer_sched
    import tinyqv_timer_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [31:0]          mtime,
    input  logic                 wr_en,
    input  logic [2:0]           rd_addr,
    input  logic [2:0]           wr_addr,
    input  logic [31:0]          data_in,
    output logic [31:0]          data_out,
    output logic [NUM_SLOTS-1:0] pending,
    output logic                 timer_irq
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_SLOTS - 1);

    logic [31:0]          cmp_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] enable_q;
    logic [NUM_SLOTS-1:0] oneshot_q;
    logic [NUM_SLOTS-1:0] pend_q;
    logic [NUM_SLOTS-1:0] irq_en_q;
    logic [1:0]           idx_q;

    logic [31:0]          cmp_sel;
    logic                 en_sel;
    logic                 hit;
    logic [NUM_SLOTS-1:0] enable_d;
    logic [NUM_SLOTS-1:0] pend_d;

    always_comb begin
        cmp_sel = '0;
        en_sel  = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (idx_q == 2'(i)) begin
                cmp_sel = cmp_q[i];
                en_sel  = enable_q[i];
            end
        end
    end

    tinyqv_timer_cmp u_cmp (
        .mtime (mtime),
        .cmp   (cmp_sel),
        .en    (en_sel),
        .hit   (hit)
    );

    // Priority per slot: CMP write > W1C clear > hit; ENABLE write > oneshot auto-disable.
    always_comb begin
        pend_d   = pend_q;
        enable_d = enable_q;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (hit && idx_q == 2'(i)) begin
                pend_d[i] = 1'b1;
                if (oneshot_q[i]) begin
                    enable_d[i] = 1'b0;
                end
            end
        end
        if (wr_en && wr_addr == ADDR_PENDING) begin
            pend_d = pend_d & ~data_in[NUM_SLOTS-1:0];
        end
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (wr_en && wr_addr == 3'(i)) begin
                pend_d[i] = 1'b0;
            end
        end
        if (wr_en && wr_addr == ADDR_ENABLE) begin
            enable_d = data_in[NUM_SLOTS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx_q     <= '0;
            enable_q  <= '0;
            oneshot_q <= '0;
            pend_q    <= '0;
            irq_en_q  <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                cmp_q[i] <= '0;
            end
        end else begin
            idx_q    <= (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
            enable_q <= enable_d;
            pend_q   <= pend_d;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (wr_en && wr_addr == 3'(i)) begin
                    cmp_q[i] <= data_in;
                end
            end
            if (wr_en && wr_addr == ADDR_ONESHOT) begin
                oneshot_q <= data_in[NUM_SLOTS-1:0];
            end
            if (wr_en && wr_addr == ADDR_IRQ_EN) begin
                irq_en_q <= data_in[NUM_SLOTS-1:0];
            end
        end
    end

    always_comb begin
        data_out = '0;
        case (rd_addr)
            ADDR_ENABLE:  data_out[NUM_SLOTS-1:0] = enable_q;
            ADDR_ONESHOT: data_out[NUM_SLOTS-1:0] = oneshot_q;
            ADDR_PENDING: data_out[NUM_SLOTS-1:0] = pend_q;
            ADDR_IRQ_EN:  data_out[NUM_SLOTS-1:0] = irq_en_q;
            default: begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    if (rd_addr == 3'(i)) begin
                        data_out = cmp_q[i];
                    end
                end
            end
        endcase
    end

    assign pending   = pend_q;
    assign timer_irq = |(pend_q & irq_en_q);

endmodule
